// File: rtl/hazard_pkg.sv
// Shared decode constants, scoreboard types and small helpers for the D-stage hazard scoreboard.
package hazard_pkg;

  typedef logic [1:0] tuse_t;
  typedef logic [1:0] tnew_t;

  // Writer position: free, or in E / M / W
  typedef enum logic [1:0] {
    AgeFree = 2'd0,
    AgeE    = 2'd1,
    AgeM    = 2'd2,
    AgeW    = 2'd3
  } age_e;

  localparam tuse_t NO_TUSE = 2'd3;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2a;
  localparam logic [5:0] F_SLTU  = 6'h2b;

  function automatic age_e age_next(input age_e a);
    case (a)
      AgeE:    return AgeM;
      AgeM:    return AgeW;
      default: return AgeFree;
    endcase
  endfunction

  // A writer only becomes a forward source once its result exists
  function automatic logic [1:0] fwd_of(input age_e a, input tnew_t t);
    if (t != '0) return FWD_GRF;
    case (a)
      AgeE:    return FWD_E;
      AgeM:    return FWD_M;
      AgeW:    return FWD_W;
      default: return FWD_GRF;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle for the hazard scoreboard.
// MDU_STALL_EN adds the E-stage MDU start/busy pair.
interface hazard_scoreboard_if;
  logic [31:0] D_Instr;
  logic        PC_En;
  logic        FD_En;
  logic        DE_Clr;
  logic [1:0]  FwdD_Rs;
  logic [1:0]  FwdD_Rt;
`ifdef MDU_STALL_EN
  logic        E_MDU_Start;
  logic        E_MDU_Busy;
`endif

  modport master (
`ifdef MDU_STALL_EN
    output E_MDU_Start,
    output E_MDU_Busy,
`endif
    output D_Instr,
    input  PC_En,
    input  FD_En,
    input  DE_Clr,
    input  FwdD_Rs,
    input  FwdD_Rt
  );

  modport slave (
`ifdef MDU_STALL_EN
    input  E_MDU_Start,
    input  E_MDU_Busy,
`endif
    input  D_Instr,
    output PC_En,
    output FD_En,
    output DE_Clr,
    output FwdD_Rs,
    output FwdD_Rt
  );
endinterface

// File: rtl/instr_class.sv
// Combinational decode of the D-stage instruction into source/destination registers,
// per-source Tuse, result Tnew and MDU membership.
module instr_class
  import hazard_pkg::*;
#(
  parameter int unsigned TNEW_ALU = 1,
  parameter int unsigned TNEW_LD  = 2,
  parameter int unsigned TNEW_LNK = 0
) (
  input  logic [31:0] instr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  dst,
  output logic        writes,
  output tuse_t       tuse_rs,
  output tuse_t       tuse_rt,
  output tnew_t       tnew,
  output logic        is_md
);
  localparam tnew_t TnewAlu = tnew_t'(TNEW_ALU);
  localparam tnew_t TnewLd  = tnew_t'(TNEW_LD);
  localparam tnew_t TnewLnk = tnew_t'(TNEW_LNK);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rd;
  logic [4:0] unused_shamt;
  logic       wr;

  assign op           = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign funct        = instr[5:0];
  assign unused_shamt = instr[10:6];

  always_comb begin
    wr      = 1'b0;
    dst     = '0;
    tuse_rs = NO_TUSE;
    tuse_rt = NO_TUSE;
    tnew    = '0;
    is_md   = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
            tuse_rs = 2'd1;
            tuse_rt = 2'd1;
            wr      = 1'b1;
            dst     = rd;
            tnew    = TnewAlu;
          end
          F_JR: tuse_rs = 2'd0;
          F_JALR: begin
            tuse_rs = 2'd0;
            wr      = 1'b1;
            dst     = rd;
            tnew    = TnewLnk;
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            tuse_rs = 2'd1;
            tuse_rt = 2'd1;
            is_md   = 1'b1;
          end
          F_MFHI, F_MFLO: begin
            wr    = 1'b1;
            dst   = rd;
            tnew  = TnewAlu;
            is_md = 1'b1;
          end
          F_MTHI, F_MTLO: begin
            tuse_rs = 2'd1;
            is_md   = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        tuse_rs = 2'd1;
        wr      = 1'b1;
        dst     = rt;
        tnew    = TnewAlu;
      end
      OP_LUI: begin
        wr   = 1'b1;
        dst  = rt;
        tnew = TnewAlu;
      end
      OP_LW: begin
        tuse_rs = 2'd1;
        wr      = 1'b1;
        dst     = rt;
        tnew    = TnewLd;
      end
      OP_SW: begin
        tuse_rs = 2'd1;
        tuse_rt = 2'd2;
      end
      OP_BEQ, OP_BNE: begin
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
      end
      OP_JAL: begin
        wr   = 1'b1;
        dst  = 5'd31;
        tnew = TnewLnk;
      end
      OP_J: ;
      default: ;
    endcase
  end

  // $0 is never tracked, so a write to it is no write at all
  assign writes = wr && (dst != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: per-register writer age/Tnew table producing stall and
// D-operand forward selects. Define MDU_STALL_EN to stall MDU ops on a busy MDU.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG     = 32,
  parameter int unsigned TNEW_ALU = 1,
  parameter int unsigned TNEW_LD  = 2,
  parameter int unsigned TNEW_LNK = 0
) (
  input logic               Clk,
  input logic               Reset,
  hazard_scoreboard_if.slave hz
);
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] dst;
  logic       writes;
  logic       is_md;
  tuse_t      tuse_rs;
  tuse_t      tuse_rt;
  tnew_t      tnew_cls;
  logic       stall;

  age_e  age_q  [NREG];
  age_e  age_d  [NREG];
  tnew_t tnew_q [NREG];
  tnew_t tnew_d [NREG];

  instr_class #(
    .TNEW_ALU(TNEW_ALU),
    .TNEW_LD (TNEW_LD),
    .TNEW_LNK(TNEW_LNK)
  ) u_instr_class (
    .instr  (hz.D_Instr),
    .rs     (rs),
    .rt     (rt),
    .dst    (dst),
    .writes (writes),
    .tuse_rs(tuse_rs),
    .tuse_rt(tuse_rt),
    .tnew   (tnew_cls),
    .is_md  (is_md)
  );

  // Unused sources carry NO_TUSE, which no Tnew can exceed
  always_comb begin
    stall = 1'b0;
    if (rs != '0 && age_q[rs] != AgeFree && tnew_q[rs] > tuse_rs) stall = 1'b1;
    if (rt != '0 && age_q[rt] != AgeFree && tnew_q[rt] > tuse_rt) stall = 1'b1;
`ifdef MDU_STALL_EN
    if (is_md && (hz.E_MDU_Start || hz.E_MDU_Busy)) stall = 1'b1;
`endif
  end

`ifndef MDU_STALL_EN
  logic unused_md;
  assign unused_md = is_md;
`endif

  always_comb begin
    for (int r = 0; r < int'(NREG); r++) begin
      age_d[r]  = age_next(age_q[r]);
      tnew_d[r] = (tnew_q[r] != '0) ? tnew_q[r] - 2'd1 : '0;
    end
    // A fresh issue replaces whatever older writer the entry held
    if (!stall && writes) begin
      age_d[dst]  = AgeE;
      tnew_d[dst] = tnew_cls;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int r = 0; r < int'(NREG); r++) begin
        age_q[r]  <= AgeFree;
        tnew_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < int'(NREG); r++) begin
        age_q[r]  <= age_d[r];
        tnew_q[r] <= tnew_d[r];
      end
    end
  end

  assign hz.PC_En   = ~stall;
  assign hz.FD_En   = ~stall;
  assign hz.DE_Clr  = stall;
  assign hz.FwdD_Rs = (rs == '0) ? FWD_GRF : fwd_of(age_q[rs], tnew_q[rs]);
  assign hz.FwdD_Rt = (rt == '0) ? FWD_GRF : fwd_of(age_q[rt], tnew_q[rt]);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard scenarios plus a randomized
// instruction stream checked against a writer-history model.
module tb_hazard_scoreboard;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  hazard_scoreboard_if hz();

  hazard_scoreboard #(
    .NREG    (32),
    .TNEW_ALU(1),
    .TNEW_LD (2),
    .TNEW_LNK(0)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .hz   (hz.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] obs;
  assign obs = {hz.PC_En, hz.FD_En, hz.DE_Clr, hz.FwdD_Rs, hz.FwdD_Rt};

  localparam logic [6:0] OK    = 7'b110_00_00;
  localparam logic [6:0] STALL = 7'b001_00_00;

  // Reference model: history of issued writers, each tagged with its issue cycle
  typedef struct {
    int rg;
    int t0;
    int tn;
  } wr_t;
  wr_t hist[$];
  int  cyc;

  function automatic logic [6:0] go(input logic [1:0] a, input logic [1:0] b);
    return {3'b110, a, b};
  endfunction

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd,
                                       input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt,
                                       input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Stage k = cycles since issue (1=E 2=M 3=W); result ready after Tnew cycles in flight
  function automatic void lookup(input int rg, output int stage, output int rem);
    stage = 0;
    rem   = 0;
    if (rg == 0) return;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].rg == rg) begin
        stage = cyc - hist[i].t0;
        if (stage > 3) stage = 0;
        else rem = (hist[i].tn - stage + 1 > 0) ? hist[i].tn - stage + 1 : 0;
        return;
      end
    end
  endfunction

  function automatic logic [6:0] model_out(input int rs_f, input int rt_f, input int tu_rs,
                                           input int tu_rt, input bit blk);
    int s;
    int r;
    bit st;
    logic [1:0] frs;
    logic [1:0] frt;
    st = blk;
    lookup(rs_f, s, r);
    if (s != 0 && tu_rs >= 0 && r > tu_rs) st = 1'b1;
    frs = (s != 0 && r == 0) ? 2'(s) : 2'd0;
    lookup(rt_f, s, r);
    if (s != 0 && tu_rt >= 0 && r > tu_rt) st = 1'b1;
    frt = (s != 0 && r == 0) ? 2'(s) : 2'd0;
    return {~st, ~st, st, frs, frt};
  endfunction

  task automatic model_edge(input bit rst, input bit st, input int dst, input int tn);
    if (rst) hist.delete();
    else if (!st && dst > 0) hist.push_back('{rg: dst, t0: cyc, tn: tn});
    cyc++;
    while (hist.size() > 0 && cyc - hist[0].t0 > 3) void'(hist.pop_front());
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset      = 1'b1;
    hz.D_Instr = '0;
    tick();
    tick();
    Reset = 1'b0;
    hist.delete();
    cyc = 0;
  endtask

  function automatic int pick();
    return ($urandom_range(0, 8) == 8) ? 31 : int'($urandom_range(0, 7));
  endfunction

  task automatic gen(output logic [31:0] ins, output int tu_rs, output int tu_rt,
                     output int dst, output int tn, output bit md);
    int k;
    int a;
    int b;
    int c;
    logic [15:0] imm;
    k     = int'($urandom_range(0, 11));
    a     = pick();
    b     = pick();
    c     = pick();
    imm   = 16'($urandom);
    tu_rs = -1;
    tu_rt = -1;
    dst   = 0;
    tn    = 0;
    md    = 1'b0;
    case (k)
      0: begin ins = r_op(a, b, c, 6'h21); tu_rs = 1; tu_rt = 1; dst = c; tn = 1; end
      1: begin ins = i_op(6'h0d, a, b, imm); tu_rs = 1; dst = b; tn = 1; end
      2: begin ins = i_op(6'h23, a, b, imm); tu_rs = 1; dst = b; tn = 2; end
      3: begin ins = i_op(6'h2b, a, b, imm); tu_rs = 1; tu_rt = 2; end
      4: begin ins = i_op(($urandom_range(0, 1) != 0) ? 6'h05 : 6'h04, a, b, imm);
               tu_rs = 0; tu_rt = 0; end
      5: begin ins = r_op(a, 0, 0, 6'h08); tu_rs = 0; end
      6: begin ins = {6'h03, 26'($urandom)}; dst = 31; tn = 0; end
      7: begin ins = r_op(a, 0, c, 6'h09); tu_rs = 0; dst = c; tn = 0; end
      8: ins = {6'h3f, 26'($urandom)};
      9: begin ins = r_op(0, 0, c, 6'h12); dst = c; tn = 1; md = 1'b1; end
      10: begin ins = r_op(a, b, 0, 6'h18); tu_rs = 1; tu_rt = 1; md = 1'b1; end
      default: begin ins = i_op(6'h0f, 0, b, imm); dst = b; tn = 1; end
    endcase
  endtask

  task automatic test_reset();
    Reset      = 1'b1;
    hz.D_Instr = '0;
    tick();
    tick();
    #2;
    n_chk++;
    if (obs !== OK) begin
      n_fail++;
      $display("FAIL reset_held: got %b expected %b", obs, OK);
    end
    Reset = 1'b0;
    tick();
    #2;
    n_chk++;
    if (obs !== OK) begin
      n_fail++;
      $display("FAIL reset_released: got %b expected %b", obs, OK);
    end
    hz.D_Instr = i_op(6'h04, 1, 1, 16'h0);
    #2;
    n_chk++;
    if (obs !== OK) begin
      n_fail++;
      $display("FAIL reset_empty_table: got %b expected %b", obs, OK);
    end
    tick();
    hist.delete();
    cyc = 0;
  endtask

  task automatic test_alu_branch();
    logic [31:0] ins  [3];
    logic [6:0]  want [3];
    do_reset();
    ins  = '{r_op(2, 3, 1, 6'h21), i_op(6'h04, 1, 0, 16'h0), i_op(6'h04, 1, 0, 16'h0)};
    want = '{OK, STALL, go(2'd2, 2'd0)};
    for (int i = 0; i < 3; i++) begin
      hz.D_Instr = ins[i];
      #2;
      n_chk++;
      if (obs !== want[i]) begin
        n_fail++;
        $display("FAIL alu_branch[%0d]: got %b expected %b", i, obs, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    logic [31:0] ins  [5];
    logic [6:0]  want [5];
    do_reset();
    ins  = '{i_op(6'h23, 5, 2, 16'h0), r_op(2, 2, 3, 6'h21), r_op(2, 2, 3, 6'h21),
             r_op(2, 2, 6, 6'h21), r_op(3, 2, 7, 6'h21)};
    want = '{OK, STALL, OK, go(2'd3, 2'd3), go(2'd2, 2'd0)};
    for (int i = 0; i < 5; i++) begin
      hz.D_Instr = ins[i];
      #2;
      n_chk++;
      if (obs !== want[i]) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got %b expected %b", i, obs, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_load_branch();
    logic [31:0] ins  [4];
    logic [6:0]  want [4];
    do_reset();
    ins  = '{i_op(6'h23, 0, 4, 16'h10), i_op(6'h04, 4, 4, 16'h0), i_op(6'h04, 4, 4, 16'h0),
             i_op(6'h04, 4, 4, 16'h0)};
    want = '{OK, STALL, STALL, go(2'd3, 2'd3)};
    for (int i = 0; i < 4; i++) begin
      hz.D_Instr = ins[i];
      #2;
      n_chk++;
      if (obs !== want[i]) begin
        n_fail++;
        $display("FAIL load_branch[%0d]: got %b expected %b", i, obs, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_link();
    logic [31:0] ins  [3];
    logic [6:0]  want [3];
    do_reset();
    ins  = '{{6'h03, 26'h0000040}, r_op(31, 0, 0, 6'h08), r_op(31, 0, 0, 6'h08)};
    want = '{OK, go(2'd1, 2'd0), go(2'd2, 2'd0)};
    for (int i = 0; i < 3; i++) begin
      hz.D_Instr = ins[i];
      #2;
      n_chk++;
      if (obs !== want[i]) begin
        n_fail++;
        $display("FAIL link[%0d]: got %b expected %b", i, obs, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_zero_and_youngest();
    logic [31:0] ins  [6];
    logic [6:0]  want [6];
    do_reset();
    ins  = '{r_op(1, 1, 0, 6'h21), i_op(6'h04, 0, 0, 16'h0), r_op(1, 1, 5, 6'h21),
             r_op(2, 2, 5, 6'h21), i_op(6'h04, 5, 0, 16'h0), i_op(6'h04, 5, 0, 16'h0)};
    want = '{OK, OK, OK, OK, STALL, go(2'd2, 2'd0)};
    for (int i = 0; i < 6; i++) begin
      hz.D_Instr = ins[i];
      #2;
      n_chk++;
      if (obs !== want[i]) begin
        n_fail++;
        $display("FAIL zero_youngest[%0d]: got %b expected %b", i, obs, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    hz.D_Instr = i_op(6'h23, 0, 7, 16'h0);
    tick();
    hz.D_Instr = i_op(6'h04, 7, 0, 16'h0);
    Reset      = 1'b1;
    #2;
    n_chk++;
    if (obs !== STALL) begin
      n_fail++;
      $display("FAIL mid_stall_before_reset: got %b expected %b", obs, STALL);
    end
    tick();
    Reset = 1'b0;
    #2;
    n_chk++;
    if (obs !== OK) begin
      n_fail++;
      $display("FAIL mid_stall_after_reset: got %b expected %b", obs, OK);
    end
    tick();
  endtask

`ifdef MDU_STALL_EN
  task automatic test_mdu_stall();
    do_reset();
    hz.E_MDU_Busy = 1'b1;
    hz.D_Instr    = r_op(0, 0, 8, 6'h12);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) hz.E_MDU_Busy = 1'b0;
      #2;
      n_chk++;
      if (obs !== ((i == 3) ? OK : STALL)) begin
        n_fail++;
        $display("FAIL mdu_stall[%0d]: got %b expected %b", i, obs, (i == 3) ? OK : STALL);
      end
      tick();
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] ins;
    logic [6:0]  want;
    int tu_rs;
    int tu_rt;
    int dst;
    int tn;
    bit md;
    bit held;
    bit rst;
    bit mdu_act;
    do_reset();
    held = 1'b0;
    ins  = '0;
    tu_rs = -1;
    tu_rt = -1;
    dst  = 0;
    tn   = 0;
    md   = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!held) gen(ins, tu_rs, tu_rt, dst, tn, md);
      rst        = ($urandom_range(0, 49) == 0);
      Reset      = rst;
      hz.D_Instr = ins;
      mdu_act    = 1'b0;
`ifdef MDU_STALL_EN
      hz.E_MDU_Start = ($urandom_range(0, 5) == 0);
      hz.E_MDU_Busy  = ($urandom_range(0, 3) == 0);
      mdu_act        = hz.E_MDU_Start || hz.E_MDU_Busy;
`endif
      #2;
      want = model_out(int'(ins[25:21]), int'(ins[20:16]), tu_rs, tu_rt, md && mdu_act);
      n_chk++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL random[%0d] instr %h: got %b expected %b", i, ins, obs, want);
      end
      tick();
      model_edge(rst, want[4], dst, tn);
      held = want[4] && !rst;
    end
    Reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    Reset      = 1'b1;
    hz.D_Instr = '0;
`ifdef MDU_STALL_EN
    hz.E_MDU_Start = 1'b0;
    hz.E_MDU_Busy  = 1'b0;
`endif
    cyc = 0;
    test_reset();
    test_alu_branch();
    test_load_use();
    test_load_branch();
    test_link();
    test_zero_and_youngest();
    test_reset_mid_stall();
`ifdef MDU_STALL_EN
    test_mdu_stall();
    hz.E_MDU_Busy = 1'b0;
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
